lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: turns one load or store from the pipeline into a single
// bus transaction. It stalls the pipeline while the transaction is in
// flight, rejects misaligned accesses, and sign- or zero-extends load data.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memwrite,
  input  logic        writeback,
  input  logic [2:0]  func210,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        ld_valid,
  output logic        misaligned,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dbe,
  input  logic        dgnt,
  input  logic        drvalid,
  input  logic [31:0] drdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Attributes of the access in flight, captured on accept
  logic        op_store_reg;
  logic [2:0]  func_reg;
  logic [1:0]  addr_lo_reg;
  logic [31:0] daddr_reg;
  logic [31:0] dwdata_reg;
  logic [3:0]  dbe_reg;
  logic [31:0] rdata_reg;

  // Request decode on the live pipeline inputs
  logic        req_any;
  logic        size_byte;
  logic        size_half;
  logic        size_word;
  logic        misalign_now;
  logic        in_idle;
  logic        accept;
  logic [3:0]  dbe_calc;
  logic [7:0]  wdata_lane [4];
  logic [31:0] wdata_rep;

  // Load data path
  logic [7:0]  rd_byte [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign req_any   = memwrite | writeback;
  // funct3[1:0]: 00 byte, 01 half, 1x word (011/110/111 behave like LW)
  assign size_byte = (func210[1:0] == 2'b00);
  assign size_half = (func210[1:0] == 2'b01);
  assign size_word = func210[1];

  assign misalign_now = (size_half & addr[0]) | (size_word & (addr[1:0] != 2'b00));
  assign in_idle      = (state_reg == IDLE);

  // Gated with rst_n so stall/misaligned drop immediately while reset is held
  assign accept     = rst_n & in_idle & req_any & ~misalign_now;
  assign misaligned = rst_n & in_idle & req_any & misalign_now;

  // Per-lane byte enables and store-data replication
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign dbe_calc[gi] = size_byte ? (addr[1:0] == 2'(gi)) :
                            size_half ? (addr[1] == 1'(gi / 2)) :
                                        1'b1;

      assign wdata_lane[gi] = size_byte ? wdata_in[7:0] :
                              size_half ? wdata_in[8*(gi%2) +: 8] :
                                          wdata_in[8*gi +: 8];

      assign rd_byte[gi] = drdata[8*gi +: 8];
    end
  endgenerate

  assign wdata_rep = {wdata_lane[3], wdata_lane[2], wdata_lane[1], wdata_lane[0]};

  // Lane select and sign/zero extension of the returning read data
  always_comb begin
    ld_byte = rd_byte[addr_lo_reg];
    ld_half = addr_lo_reg[1] ? drdata[31:16] : drdata[15:0];
    case (func_reg)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = drdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and pipeline stall; DONE never accepts a new request
  // because whatever is on the inputs then belongs to the retiring instruction
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dgnt) begin
          state_next = op_store_reg ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (drvalid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the access on accept; bus fields stay frozen until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_store_reg <= 1'b0;
      func_reg     <= 3'd0;
      addr_lo_reg  <= 2'd0;
      daddr_reg    <= 32'd0;
      dwdata_reg   <= 32'd0;
      dbe_reg      <= 4'd0;
    end else if (accept) begin
      op_store_reg <= memwrite;
      func_reg     <= func210;
      addr_lo_reg  <= addr[1:0];
      daddr_reg    <= {addr[31:2], 2'b00};
      dwdata_reg   <= wdata_rep;
      dbe_reg      <= dbe_calc;
    end
  end

  // Load result register: only a read beat accepted in WAIT updates it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= 32'd0;
    end else if ((state_reg == WAIT) && drvalid) begin
      rdata_reg <= ld_ext;
    end
  end

  // Bus strobes only while requesting, so the bus sees zeros when idle
  assign dreq      = (state_reg == REQ);
  assign dwe       = (state_reg == REQ) & op_store_reg;
  assign dbe       = (state_reg == REQ) ? dbe_reg : 4'd0;
  assign daddr     = daddr_reg;
  assign dwdata    = dwdata_reg;
  assign ld_valid  = (state_reg == DONE) & ~op_store_reg;
  assign rdata_out = rdata_reg;

endmodule
